// File: rtl/vrf_dispatch_pkg.sv
// Shared constants and types for the vrf_dispatch register file / operand dispatcher.
// Default geometry, register-operand encoding, micro-op field layout and slot state.
package vrf_dispatch_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int VLEN_DEF    = 128;
  localparam int NREG_S_DEF  = 32;
  localparam int NREG_V_DEF  = 32;
  localparam int NUM_EXU_DEF = 2;
  localparam int UOP_W_DEF   = 64;

  // Register operand: bit 5 selects the vector file, bits 4:0 index within the file.
  localparam int REG_W         = 6;
  localparam int REG_CLASS_BIT = 5;
  localparam int REG_IDX_W     = 5;

  // Micro-op layout {pos,opt,funct3,funct6,rd,imm}; the dispatcher never decodes it.
  localparam int UOP_IMM_LSB    = 0;
  localparam int UOP_IMM_W      = 32;
  localparam int UOP_RD_LSB     = 32;
  localparam int UOP_RD_W       = 6;
  localparam int UOP_FUNCT6_LSB = 38;
  localparam int UOP_FUNCT6_W   = 6;
  localparam int UOP_FUNCT3_LSB = 44;
  localparam int UOP_FUNCT3_W   = 3;
  localparam int UOP_OPT_LSB    = 47;
  localparam int UOP_OPT_W      = 8;
  localparam int UOP_POS_LSB    = 55;
  localparam int UOP_POS_W      = 9;

  localparam int EXU_ALU = 0;
  localparam int EXU_LS  = 1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic isVector(input logic [REG_W-1:0] reg_sel);
    return reg_sel[REG_CLASS_BIT];
  endfunction

endpackage

// File: rtl/vrf_dispatch_if.sv
// Scoreboard issue, write-back and per-EXU dispatch bundle for vrf_dispatch.
// slave = the dispatcher, master = the scoreboard/EXU/write-back environment.
interface vrf_dispatch_if
  import vrf_dispatch_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int VLEN    = VLEN_DEF,
  parameter int NUM_EXU = NUM_EXU_DEF,
  parameter int UOP_W   = UOP_W_DEF
) ();

  localparam int DEST_W = (NUM_EXU > 1) ? $clog2(NUM_EXU) : 1;

  logic                     sb_valid;
  logic                     sb_ready;
  logic [DEST_W-1:0]        sb_dest;
  logic [REG_W-1:0]         sb_rs1;
  logic [REG_W-1:0]         sb_rs2;
  logic [UOP_W-1:0]         sb_uop;

  logic                     wb_valid;
  logic [REG_W-1:0]         wb_rd;
  logic [VLEN-1:0]          wb_value;
  logic [VLEN/8-1:0]        wb_be;

  logic [NUM_EXU-1:0]       exu_valid;
  logic [NUM_EXU-1:0]       exu_ready;
  logic [NUM_EXU*VLEN-1:0]  exu_value1;
  logic [NUM_EXU*VLEN-1:0]  exu_value2;
  logic [NUM_EXU*UOP_W-1:0] exu_uop;

  modport slave (
    input  sb_valid, sb_dest, sb_rs1, sb_rs2, sb_uop,
    input  wb_valid, wb_rd, wb_value, wb_be,
    input  exu_ready,
    output sb_ready,
    output exu_valid, exu_value1, exu_value2, exu_uop
  );

  modport master (
    output sb_valid, sb_dest, sb_rs1, sb_rs2, sb_uop,
    output wb_valid, wb_rd, wb_value, wb_be,
    output exu_ready,
    input  sb_ready,
    input  exu_valid, exu_value1, exu_value2, exu_uop
  );

endinterface

// File: rtl/vrf_dispatch_exu_out_slot.sv
// One valid/ready output holding register feeding a single execution unit.
// Holds operands and micro-op until accepted; a load on the accept cycle refills in place.
module vrf_dispatch_exu_out_slot
  import vrf_dispatch_pkg::*;
#(
  parameter int VLEN  = VLEN_DEF,
  parameter int UOP_W = UOP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [VLEN-1:0]  i_load_value1,
  input  logic [VLEN-1:0]  i_load_value2,
  input  logic [UOP_W-1:0] i_load_uop,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [VLEN-1:0]  o_value1,
  output logic [VLEN-1:0]  o_value2,
  output logic [UOP_W-1:0] o_uop
);

  slot_state_e      r_state;
  logic [VLEN-1:0]  r_value1;
  logic [VLEN-1:0]  r_value2;
  logic [UOP_W-1:0] r_uop;

  // The dispatcher only asserts i_load when the slot is empty or draining this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= SLOT_EMPTY;
      r_value1 <= '0;
      r_value2 <= '0;
      r_uop    <= '0;
    end else if (i_load) begin
      r_state  <= SLOT_FULL;
      r_value1 <= i_load_value1;
      r_value2 <= i_load_value2;
      r_uop    <= i_load_uop;
    end else if ((r_state == SLOT_FULL) && i_ready) begin
      r_state  <= SLOT_EMPTY;
    end
  end

  assign o_valid  = (r_state == SLOT_FULL);
  assign o_value1 = r_value1;
  assign o_value2 = r_value2;
  assign o_uop    = r_uop;

endmodule

// File: rtl/vrf_dispatch.sv
// Unified scalar/vector register file with per-EXU operand dispatch and byte-enabled write-back.
// Optional WB_BYPASS_EN: same-cycle write-back data is merged into operands read at issue.
module vrf_dispatch
  import vrf_dispatch_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int VLEN    = VLEN_DEF,
  parameter int NREG_S  = NREG_S_DEF,
  parameter int NREG_V  = NREG_V_DEF,
  parameter int NUM_EXU = NUM_EXU_DEF,
  parameter int UOP_W   = UOP_W_DEF
) (
  input logic          clk,
  input logic          rst,
  vrf_dispatch_if.slave bus
);

  localparam int NBYTE_V = VLEN / 8;
  localparam int NBYTE_S = XLEN / 8;
  localparam int DEST_W  = (NUM_EXU > 1) ? $clog2(NUM_EXU) : 1;

  logic [XLEN-1:0]    r_sreg [NREG_S];
  logic [VLEN-1:0]    r_vreg [NREG_V];

  logic [VLEN-1:0]    w_operand [2];
  logic [REG_W-1:0]   w_rsSel;
  logic [DEST_W-1:0]  w_dest;
  logic               w_destOk;
  logic               w_sbReady;
  logic               w_fire;
  logic [NUM_EXU-1:0] w_slotValid;

  // Scalar writes ignore enables above XLEN; x0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG_S; i++) r_sreg[i] <= '0;
      for (int i = 0; i < NREG_V; i++) r_vreg[i] <= '0;
    end else if (bus.wb_valid) begin
      if (isVector(bus.wb_rd)) begin
        for (int b = 0; b < NBYTE_V; b++)
          if (bus.wb_be[b]) r_vreg[bus.wb_rd[REG_IDX_W-1:0]][b*8 +: 8] <= bus.wb_value[b*8 +: 8];
      end else if (bus.wb_rd[REG_IDX_W-1:0] != '0) begin
        for (int b = 0; b < NBYTE_S; b++)
          if (bus.wb_be[b]) r_sreg[bus.wb_rd[REG_IDX_W-1:0]][b*8 +: 8] <= bus.wb_value[b*8 +: 8];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < 2; o++) begin
      w_rsSel      = (o == 0) ? bus.sb_rs1 : bus.sb_rs2;
      w_operand[o] = '0;
      if (isVector(w_rsSel))
        w_operand[o] = r_vreg[w_rsSel[REG_IDX_W-1:0]];
      else if (w_rsSel[REG_IDX_W-1:0] != '0)
        w_operand[o] = {{(VLEN-XLEN){1'b0}}, r_sreg[w_rsSel[REG_IDX_W-1:0]]};
`ifdef WB_BYPASS_EN
      if (bus.wb_valid && (bus.wb_rd == w_rsSel) &&
          (isVector(w_rsSel) || (w_rsSel[REG_IDX_W-1:0] != '0))) begin
        for (int b = 0; b < NBYTE_V; b++)
          if (bus.wb_be[b] && (isVector(w_rsSel) || (b < NBYTE_S)))
            w_operand[o][b*8 +: 8] = bus.wb_value[b*8 +: 8];
      end
`endif
    end
  end

  // An out-of-range destination is never ready, so such an issue can never fire.
  assign w_dest    = bus.sb_dest;
  assign w_destOk  = (32'(w_dest) < NUM_EXU);
  assign w_sbReady = w_destOk & (~w_slotValid[w_dest] | bus.exu_ready[w_dest]);
  assign w_fire    = bus.sb_valid & w_sbReady;
  assign bus.sb_ready = w_sbReady;

  for (genvar k = 0; k < NUM_EXU; k++) begin : g_slot
    logic             w_load;
    logic [VLEN-1:0]  w_value1;
    logic [VLEN-1:0]  w_value2;
    logic [UOP_W-1:0] w_uop;

    assign w_load = w_fire && (32'(w_dest) == k);

    vrf_dispatch_exu_out_slot #(
      .VLEN  (VLEN),
      .UOP_W (UOP_W)
    ) u_slot (
      .clk           (clk),
      .rst           (rst),
      .i_load        (w_load),
      .i_load_value1 (w_operand[0]),
      .i_load_value2 (w_operand[1]),
      .i_load_uop    (bus.sb_uop),
      .i_ready       (bus.exu_ready[k]),
      .o_valid       (w_slotValid[k]),
      .o_value1      (w_value1),
      .o_value2      (w_value2),
      .o_uop         (w_uop)
    );

    assign bus.exu_value1[k*VLEN +: VLEN]   = w_value1;
    assign bus.exu_value2[k*VLEN +: VLEN]   = w_value2;
    assign bus.exu_uop[k*UOP_W +: UOP_W]    = w_uop;
  end

  assign bus.exu_valid = w_slotValid;

endmodule

// File: tb/tb_vrf_dispatch.sv
// Directed self-checking bench for vrf_dispatch (default geometry, 2 EXUs).
// Expected values are hand-computed; WB_BYPASS_EN selects the same-cycle read expectation.
module tb_vrf_dispatch;
  import vrf_dispatch_pkg::*;

  localparam logic [5:0] X0 = 6'd0;
  localparam logic [5:0] X5 = 6'd5;
  localparam logic [5:0] X6 = 6'd6;
  localparam logic [5:0] V3 = 6'b100011;
  localparam logic [5:0] V7 = 6'b100111;

  localparam logic [127:0] V3_EXP  = 128'h0000_0000_0000_0000_1111_1111_1111_1111;
  localparam logic [127:0] V7_OLD  = {16{8'h3C}};
  localparam logic [127:0] V7_NEW  = {16{8'hA5}};
  localparam logic [127:0] SCALAR_WB = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEAD_BEEF};

  localparam logic [63:0] U_A = 64'hA000_0000_0000_00AA;
  localparam logic [63:0] U_0 = 64'h1000_0000_0000_0010;
  localparam logic [63:0] U_1 = 64'h2000_0000_0000_0021;
  localparam logic [63:0] U_2 = 64'h3000_0000_0000_0032;
  localparam logic [63:0] U_3 = 64'h4000_0000_0000_0043;
  localparam logic [63:0] U_4 = 64'h5000_0000_0000_0054;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vrf_dispatch_if bus ();

  vrf_dispatch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] chV1(input int k);
    return bus.exu_value1[k*128 +: 128];
  endfunction

  function automatic logic [127:0] chV2(input int k);
    return bus.exu_value2[k*128 +: 128];
  endfunction

  function automatic logic [63:0] chUop(input int k);
    return bus.exu_uop[k*64 +: 64];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic d, input logic [5:0] r1,
                               input logic [5:0] r2, input logic [63:0] uop);
    bus.sb_valid = v;
    bus.sb_dest  = d;
    bus.sb_rs1   = r1;
    bus.sb_rs2   = r2;
    bus.sb_uop   = uop;
  endtask

  task automatic applyWb(input logic v, input logic [5:0] rd, input logic [127:0] val,
                         input logic [15:0] be);
    bus.wb_valid = v;
    bus.wb_rd    = rd;
    bus.wb_value = val;
    bus.wb_be    = be;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, X0, X0, '0);
    applyWb(1'b0, X0, '0, '0);
    bus.exu_ready = 2'b00;

    // Reset state while rst is held
    #2;
    checkOutput("rst_valid", 128'(bus.exu_valid), 128'd0);
    checkOutput("rst_v1_ch0", chV1(0), 128'd0);
    checkOutput("rst_v2_ch1", chV2(1), 128'd0);
    checkOutput("rst_uop", 128'(bus.exu_uop), 128'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_sb_ready", 128'(bus.sb_ready), 128'd1);
    tick();

    // 1: partial-byte vector write, then read to EXU 1
    $display("[TB] step 1: vector byte-enable write and dispatch");
    applyWb(1'b1, V3, {16{8'h11}}, 16'h00FF);
    tick();
    applyWb(1'b0, X0, '0, '0);
    applyStimulus(1'b1, 1'b1, V3, X0, U_A);
    tick();
    applyStimulus(1'b0, 1'b0, X0, X0, '0);
    checkOutput("t1_valid", 128'(bus.exu_valid), 128'b10);
    checkOutput("t1_v1_ch1", chV1(1), V3_EXP);
    checkOutput("t1_v2_ch1", chV2(1), 128'd0);
    checkOutput("t1_uop_ch1", 128'(chUop(1)), 128'(U_A));
    bus.exu_ready = 2'b10;
    tick();
    checkOutput("t1_drain_valid", 128'(bus.exu_valid), 128'b00);
    bus.exu_ready = 2'b00;

    // 2: slot 0 stalled for 3 cycles, dest 1 accepted meanwhile
    $display("[TB] step 2: backpressure on slot 0");
    applyStimulus(1'b1, 1'b0, V3, X0, U_0);
    tick();
    checkOutput("t2_load_valid", 128'(bus.exu_valid), 128'b01);
    applyStimulus(1'b1, 1'b0, X0, X0, U_1);
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("t2_stall_sb_ready", 128'(bus.sb_ready), 128'd0);
      tick();
      checkOutput("t2_hold_valid0", 128'(bus.exu_valid[0]), 128'd1);
      checkOutput("t2_hold_uop0", 128'(chUop(0)), 128'(U_0));
      checkOutput("t2_hold_v1_ch0", chV1(0), V3_EXP);
    end
    applyStimulus(1'b1, 1'b1, X0, V3, U_1);
    #1;
    checkOutput("t2_dest1_sb_ready", 128'(bus.sb_ready), 128'd1);
    tick();
    applyStimulus(1'b0, 1'b0, X0, X0, '0);
    checkOutput("t2_both_valid", 128'(bus.exu_valid), 128'b11);
    checkOutput("t2_uop_ch1", 128'(chUop(1)), 128'(U_1));
    checkOutput("t2_v2_ch1", chV2(1), V3_EXP);
    checkOutput("t2_uop_ch0_kept", 128'(chUop(0)), 128'(U_0));
    bus.exu_ready = 2'b10;
    tick();
    checkOutput("t2_drain1_valid", 128'(bus.exu_valid), 128'b01);

    // 3: drain and refill slot 0 in the same cycle
    $display("[TB] step 3: drain and refill");
    bus.exu_ready = 2'b01;
    applyStimulus(1'b1, 1'b0, X0, X0, U_2);
    #1;
    checkOutput("t3_sb_ready", 128'(bus.sb_ready), 128'd1);
    tick();
    applyStimulus(1'b0, 1'b0, X0, X0, '0);
    checkOutput("t3_valid0_stays", 128'(bus.exu_valid), 128'b01);
    checkOutput("t3_uop_ch0", 128'(chUop(0)), 128'(U_2));
    tick();
    checkOutput("t3_drain_valid", 128'(bus.exu_valid), 128'b00);
    bus.exu_ready = 2'b00;

    // 4: x0 discards writes, scalar write honours only low enables, zero-extended read
    $display("[TB] step 4: scalar write-back rules");
    applyWb(1'b1, X0, SCALAR_WB, 16'hFFFF);
    tick();
    applyWb(1'b1, X5, SCALAR_WB, 16'hFFFF);
    tick();
    applyWb(1'b1, X6, {96'h0, 32'h1234_5678}, 16'h0003);
    applyStimulus(1'b1, 1'b0, X0, X5, U_3);
    tick();
    applyWb(1'b0, X0, '0, '0);
    checkOutput("t4_x0_reads_zero", chV1(0), 128'd0);
    checkOutput("t4_x5_zero_ext", chV2(0), 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    applyStimulus(1'b1, 1'b1, X6, X0, U_3);
    tick();
    applyStimulus(1'b0, 1'b0, X0, X0, '0);
    checkOutput("t4_x6_partial_be", chV1(1), 128'h5678);
    bus.exu_ready = 2'b11;
    tick();
    checkOutput("t4_drain_valid", 128'(bus.exu_valid), 128'b00);
    bus.exu_ready = 2'b00;

    // 5: read of a register written in the same cycle
    $display("[TB] step 5: same-cycle write-back and read");
    applyWb(1'b1, V7, V7_OLD, 16'hFFFF);
    tick();
    applyWb(1'b1, V7, V7_NEW, 16'hFFFF);
    applyStimulus(1'b1, 1'b1, V7, X0, U_4);
    tick();
    applyWb(1'b0, X0, '0, '0);
`ifdef WB_BYPASS_EN
    checkOutput("t5_same_cycle_read", chV1(1), V7_NEW);
`else
    checkOutput("t5_same_cycle_read", chV1(1), V7_OLD);
`endif
    applyStimulus(1'b1, 1'b0, V7, X0, U_4);
    tick();
    applyStimulus(1'b0, 1'b0, X0, X0, '0);
    checkOutput("t5_later_read", chV1(0), V7_NEW);

    // 6: asynchronous reset while both slots hold ops
    $display("[TB] step 6: asynchronous reset with full slots");
    checkOutput("t6_pre_valid", 128'(bus.exu_valid), 128'b11);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_async_valid", 128'(bus.exu_valid), 128'b00);
    checkOutput("t6_async_v1_ch0", chV1(0), 128'd0);
    checkOutput("t6_async_v1_ch1", chV1(1), 128'd0);
    checkOutput("t6_async_uop", 128'(bus.exu_uop), 128'd0);
    rst = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, V3, X5, U_1);
    tick();
    applyStimulus(1'b0, 1'b0, X0, X0, '0);
    checkOutput("t6_after_valid", 128'(bus.exu_valid), 128'b01);
    checkOutput("t6_v3_cleared", chV1(0), 128'd0);
    checkOutput("t6_x5_cleared", chV2(0), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
